// File: rtl/writeback_arbiter_pkg.sv
// Shared pipeline definitions for the writeback arbiter: default widths/depth
// and the pipe identifier used by the round-robin pointer.
package writeback_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;

  typedef enum logic {
    PIPE_A = 1'b0,
    PIPE_B = 1'b1
  } pipe_e;

  function automatic pipe_e other_pipe(input pipe_e p);
    return (p == PIPE_A) ? PIPE_B : PIPE_A;
  endfunction

endpackage

// File: rtl/writeback_arbiter_result_fifo.sv
// Per-pipe result buffer: power-of-two circular FIFO with occupancy count.
// Caller gates push/pop; push while full is legal only together with a pop.
module result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = DEF_REG_ADDR_WIDTH + DEF_DATA_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges results from two execute pipes into one register-file write port,
// with per-pipe buffering, round-robin arbitration and a registered write stage.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enableA_i,
  input  logic                      enableB_i,
  input  logic [REG_ADDR_WIDTH-1:0] regAddrA_i,
  input  logic [REG_ADDR_WIDTH-1:0] regAddrB_i,
  input  logic [DATA_WIDTH-1:0]     dataA_i,
  input  logic [DATA_WIDTH-1:0]     dataB_i,
  output logic                      isStalledA_o,
  output logic                      isStalledB_o,
  input  logic                      shouldStall_i,
  output logic                      regWriteEnable_o,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddr_o,
  output logic [DATA_WIDTH-1:0]     regWriteData_o,
  output logic                      releaseEnable_o,
  output logic [REG_ADDR_WIDTH-1:0] releaseReg_o,
  output logic                      overflowA_o,
  output logic                      overflowB_o,
  output logic                      idle_o
);

  localparam int unsigned ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic               push_a, push_b, grant_a, grant_b;
  logic               full_a, full_b, empty_a, empty_b;
  logic [CNT_W-1:0]   count_a, count_b;
  logic [ENTRY_W-1:0] entry_a, entry_b;

  pipe_e              rr_q, rr_d;
  logic               overflow_a_q, overflow_a_d;
  logic               overflow_b_q, overflow_b_d;
  logic               wr_en_q, wr_en_d;
  logic [ENTRY_W-1:0] wr_entry_q, wr_entry_d;

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo_a (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push_a),
    .pop_i   (grant_a),
    .data_i  ({regAddrA_i, dataA_i}),
    .data_o  (entry_a),
    .full_o  (full_a),
    .empty_o (empty_a),
    .count_o (count_a)
  );

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo_b (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push_b),
    .pop_i   (grant_b),
    .data_i  ({regAddrB_i, dataB_i}),
    .data_o  (entry_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .count_o (count_b)
  );

  // The pointer only advances on contended grants, so a lone pipe draining
  // does not steal the other pipe's next turn.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    if (!shouldStall_i) begin
      if (!empty_a && !empty_b) begin
        grant_a = (rr_q == PIPE_A);
        grant_b = (rr_q == PIPE_B);
        rr_d    = other_pipe(rr_q);
      end else if (!empty_a) begin
        grant_a = 1'b1;
      end else if (!empty_b) begin
        grant_b = 1'b1;
      end
    end
  end

  // A full FIFO still accepts when it is popped in the same cycle.
  always_comb begin
    push_a       = enableA_i && (!full_a || grant_a);
    push_b       = enableB_i && (!full_b || grant_b);
    overflow_a_d = overflow_a_q || (enableA_i && full_a && !grant_a);
    overflow_b_d = overflow_b_q || (enableB_i && full_b && !grant_b);
    wr_en_d      = grant_a || grant_b;
    wr_entry_d   = wr_entry_q;
    if (grant_a)      wr_entry_d = entry_a;
    else if (grant_b) wr_entry_d = entry_b;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      rr_q         <= PIPE_A;
      overflow_a_q <= 1'b0;
      overflow_b_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_entry_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      overflow_a_q <= overflow_a_d;
      overflow_b_q <= overflow_b_d;
      wr_en_q      <= wr_en_d;
      wr_entry_q   <= wr_entry_d;
    end
  end

  assign isStalledA_o     = full_a;
  assign isStalledB_o     = full_b;
  assign regWriteEnable_o = wr_en_q;
  assign regWriteAddr_o   = wr_entry_q[ENTRY_W-1:DATA_WIDTH];
  assign regWriteData_o   = wr_entry_q[DATA_WIDTH-1:0];
  assign releaseEnable_o  = wr_en_q;
  assign releaseReg_o     = wr_entry_q[ENTRY_W-1:DATA_WIDTH];
  assign overflowA_o      = overflow_a_q;
  assign overflowB_o      = overflow_b_q;
  assign idle_o           = (count_a == '0) && (count_b == '0) && !wr_en_q;

endmodule
